// File: rtl/clock_core.sv
// Alarm clock timekeeping core: 24-hour BCD time with a binary seconds
// counter, a settable BCD alarm time, a mode FSM and the buzzer control.
// Every output comes straight from a flop.
module clock_core #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BUZZ_SECS     = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic       alarm_en,
  input  logic       stop,
  output logic [3:0] c_min1,
  output logic [3:0] c_min2,
  output logic [3:0] c_hr1,
  output logic [3:0] c_hr2,
  output logic [3:0] a_min1,
  output logic [3:0] a_min2,
  output logic [3:0] a_hr1,
  output logic [3:0] a_hr2,
  output logic       alarm,
  output logic       buzz
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int BW = $clog2(BUZZ_SECS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_SECS - 1);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_SET_TIME  = 2'd1;
  localparam logic [1:0] ST_SET_ALARM = 2'd2;

  // Two-digit BCD increment that wraps to 00 after 'last' (59 or 23).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [1:0]    state_reg, state_next;
  logic          alarm_reg;
  logic [PW-1:0] presc_reg;
  logic [5:0]    sec_reg;
  logic [7:0]    c_min_reg, c_hr_reg, c_min_next, c_hr_next;
  logic [7:0]    a_min_reg, a_hr_reg, a_min_next, a_hr_next;
  logic          buzz_reg;
  logic [BW-1:0] buzz_cnt_reg;

  // Button edge detection: bit 0 inc_min, bit 1 inc_hr, bit 2 stop.
  logic [2:0] btn;
  logic [2:0] btn_rise;
  assign btn = {stop, inc_hr, inc_min};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic q_reg;
      // Remember last level so a held button yields a single event.
      always_ff @(posedge clk) begin
        if (!rst_n) q_reg <= 1'b0;
        else        q_reg <= btn[gi];
      end
      assign btn_rise[gi] = btn[gi] & ~q_reg;
    end
  endgenerate

  logic rise_min, rise_hr, rise_stop;
  assign rise_min  = btn_rise[0];
  assign rise_hr   = btn_rise[1];
  assign rise_stop = btn_rise[2];

  // Time only runs outside SET_TIME; the carry chain starts from sec_tick.
  logic sec_tick, min_carry, hr_carry;
  assign sec_tick  = (state_reg != ST_SET_TIME) && (presc_reg == PRESC_LAST);
  assign min_carry = sec_tick && (sec_reg == 6'd59);
  assign hr_carry  = min_carry && (c_min_reg == 8'h59);

  // Next time/alarm digits: edits in the setting modes, carries otherwise.
  always_comb begin
    c_min_next = c_min_reg;
    c_hr_next  = c_hr_reg;
    a_min_next = a_min_reg;
    a_hr_next  = a_hr_reg;
    if (state_reg == ST_SET_TIME) begin
      if (rise_min) c_min_next = bcd_inc(c_min_reg, 8'h59);
      if (rise_hr)  c_hr_next  = bcd_inc(c_hr_reg, 8'h23);
    end else begin
      if (min_carry) c_min_next = bcd_inc(c_min_reg, 8'h59);
      if (hr_carry)  c_hr_next  = bcd_inc(c_hr_reg, 8'h23);
      if (state_reg == ST_SET_ALARM) begin
        if (rise_min) a_min_next = bcd_inc(a_min_reg, 8'h59);
        if (rise_hr)  a_hr_next  = bcd_inc(a_hr_reg, 8'h23);
      end
    end
  end

  // Same next state from every state: set_time wins over set_alarm.
  always_comb begin
    if (set_time)       state_next = ST_SET_TIME;
    else if (set_alarm) state_next = ST_SET_ALARM;
    else                state_next = ST_RUN;
  end

  // Buzzer triggers only on a carry landing on the alarm minute; editing never does.
  logic alarm_match, buzz_done, buzz_clr;
  assign alarm_match = min_carry && alarm_en &&
                       ({c_hr_next, c_min_next} == {a_hr_reg, a_min_reg});
  assign buzz_done   = buzz_reg && sec_tick && (buzz_cnt_reg == BUZZ_LAST);
  assign buzz_clr    = rise_stop || !alarm_en || buzz_done;

  // Prescaler and seconds counter, both frozen at 0 while setting the time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg <= '0;
      sec_reg   <= 6'd0;
    end else if (state_reg == ST_SET_TIME) begin
      presc_reg <= '0;
      sec_reg   <= 6'd0;
    end else if (sec_tick) begin
      presc_reg <= '0;
      sec_reg   <= (sec_reg == 6'd59) ? 6'd0 : sec_reg + 6'd1;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Time and alarm digit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_min_reg <= 8'h00;
      c_hr_reg  <= 8'h00;
      a_min_reg <= 8'h00;
      a_hr_reg  <= 8'h00;
    end else begin
      c_min_reg <= c_min_next;
      c_hr_reg  <= c_hr_next;
      a_min_reg <= a_min_next;
      a_hr_reg  <= a_hr_next;
    end
  end

  // Mode FSM; the view select follows the state it enters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      alarm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      alarm_reg <= (state_next == ST_SET_ALARM);
    end
  end

  // Buzzer with its seconds-on counter; clearing beats setting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buzz_reg     <= 1'b0;
      buzz_cnt_reg <= '0;
    end else if (buzz_clr) begin
      buzz_reg     <= 1'b0;
      buzz_cnt_reg <= '0;
    end else if (alarm_match) begin
      buzz_reg     <= 1'b1;
      buzz_cnt_reg <= '0;
    end else if (buzz_reg && sec_tick) begin
      buzz_cnt_reg <= buzz_cnt_reg + BW'(1);
    end
  end

  assign c_min1 = c_min_reg[3:0];
  assign c_min2 = c_min_reg[7:4];
  assign c_hr1  = c_hr_reg[3:0];
  assign c_hr2  = c_hr_reg[7:4];
  assign a_min1 = a_min_reg[3:0];
  assign a_min2 = a_min_reg[7:4];
  assign a_hr1  = a_hr_reg[3:0];
  assign a_hr2  = a_hr_reg[7:4];
  assign alarm  = alarm_reg;
  assign buzz   = buzz_reg;

endmodule

// File: tb/tb_clock_core.sv
// Scoreboard bench for clock_core. The driver applies one input vector per
// cycle, advances a seconds-of-day reference model and queues the expected
// outputs; the monitor pops one entry per clock and compares.
module tb_clock_core;

  localparam int TPS  = 4;
  localparam int BUZZ = 3;
  localparam int M_RUN = 0, M_ST = 1, M_SA = 2;

  logic clk = 1'b0;
  logic rst_n, set_time, set_alarm, inc_min, inc_hr, alarm_en, stop;
  logic [3:0] c_min1, c_min2, c_hr1, c_hr2, a_min1, a_min2, a_hr1, a_hr2;
  logic alarm, buzz;

  always #5 clk = ~clk;

  clock_core #(.TICKS_PER_SEC(TPS), .BUZZ_SECS(BUZZ)) dut (
    .clk(clk), .rst_n(rst_n), .set_time(set_time), .set_alarm(set_alarm),
    .inc_min(inc_min), .inc_hr(inc_hr), .alarm_en(alarm_en), .stop(stop),
    .c_min1(c_min1), .c_min2(c_min2), .c_hr1(c_hr1), .c_hr2(c_hr2),
    .a_min1(a_min1), .a_min2(a_min2), .a_hr1(a_hr1), .a_hr2(a_hr2),
    .alarm(alarm), .buzz(buzz)
  );

  typedef struct packed {
    logic [15:0] c;
    logic [15:0] a;
    logic        alm;
    logic        bz;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: time as seconds of day, alarm as minute of day.
  int m_tsec, m_presc, m_alarm_m, m_st, m_bcnt;
  bit m_buzz, m_pm, m_ph, m_ps;

  function automatic logic [15:0] hm_digits(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic model_step();
    int h, m, old_alarm;
    bit rm, rh, rs, tick, carry, done, clr, setb;
    if (!rst_n) begin
      m_tsec = 0; m_presc = 0; m_alarm_m = 0; m_st = M_RUN;
      m_buzz = 0; m_bcnt = 0; m_pm = 0; m_ph = 0; m_ps = 0;
    end else begin
      rm = inc_min && !m_pm;
      rh = inc_hr && !m_ph;
      rs = stop && !m_ps;
      old_alarm = m_alarm_m;
      tick  = (m_st != M_ST) && (m_presc == TPS - 1);
      carry = tick && (m_tsec % 60 == 59);
      if (m_st == M_ST) begin
        m_presc = 0;
        h = m_tsec / 3600;
        m = (m_tsec / 60) % 60;
        if (rm) m = (m + 1) % 60;
        if (rh) h = (h + 1) % 24;
        m_tsec = h * 3600 + m * 60;
      end else begin
        m_presc = tick ? 0 : m_presc + 1;
        if (tick) m_tsec = (m_tsec + 1) % 86400;
        if (m_st == M_SA) begin
          h = m_alarm_m / 60;
          m = m_alarm_m % 60;
          if (rm) m = (m + 1) % 60;
          if (rh) h = (h + 1) % 24;
          m_alarm_m = h * 60 + m;
        end
      end
      setb = carry && alarm_en && (m_tsec / 60 == old_alarm);
      done = m_buzz && tick && (m_bcnt + 1 >= BUZZ);
      clr  = rs || !alarm_en || done;
      if (clr) begin
        m_buzz = 0; m_bcnt = 0;
      end else if (setb) begin
        m_buzz = 1; m_bcnt = 0;
      end else if (m_buzz && tick) begin
        m_bcnt++;
      end
      m_st = set_time ? M_ST : (set_alarm ? M_SA : M_RUN);
      m_pm = inc_min; m_ph = inc_hr; m_ps = stop;
    end
  endtask

  // One clock of stimulus: model, queue expectation, let the edge happen.
  task automatic step();
    exp_t e;
    model_step();
    e.c   = hm_digits(m_tsec / 3600, (m_tsec / 60) % 60);
    e.a   = hm_digits(m_alarm_m / 60, m_alarm_m % 60);
    e.alm = (m_st == M_SA);
    e.bz  = m_buzz;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_min();
    inc_min = 1'b1; step(); inc_min = 1'b0; step();
  endtask

  task automatic pulse_hr();
    inc_hr = 1'b1; step(); inc_hr = 1'b0; step();
  endtask

  task automatic set_time_to(input int h, input int m);
    int nh, nm;
    set_time = 1'b1; step();
    nh = (h - m_tsec / 3600 + 24) % 24;
    nm = (m - (m_tsec / 60) % 60 + 60) % 60;
    for (int i = 0; i < nh; i++) pulse_hr();
    for (int i = 0; i < nm; i++) pulse_min();
    set_time = 1'b0; step();
  endtask

  task automatic set_alarm_to(input int h, input int m);
    int nh, nm;
    set_alarm = 1'b1; step();
    nh = (h - m_alarm_m / 60 + 24) % 24;
    nm = (m - m_alarm_m % 60 + 60) % 60;
    for (int i = 0; i < nh; i++) pulse_hr();
    for (int i = 0; i < nm; i++) pulse_min();
    set_alarm = 1'b0; step();
  endtask

  task automatic note(input string tag);
    $display("[%s] model time %02d:%02d:%02d alarm %02d:%02d buzz=%0d",
             tag, m_tsec / 3600, (m_tsec / 60) % 60, m_tsec % 60,
             m_alarm_m / 60, m_alarm_m % 60, m_buzz);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: outputs are registered, so compare just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("c_time", {c_hr2, c_hr1, c_min2, c_min1}, e.c);
      chk("a_time", {a_hr2, a_hr1, a_min2, a_min1}, e.a);
      chk("alarm", {15'd0, alarm}, {15'd0, e.alm});
      chk("buzz", {15'd0, buzz}, {15'd0, e.bz});
    end
  end

  initial begin
    rst_n = 1'b0; set_time = 1'b0; set_alarm = 1'b0; inc_min = 1'b0;
    inc_hr = 1'b0; alarm_en = 1'b0; stop = 1'b0;
    @(negedge clk);

    // Reset, then one minute of running.
    run(2);
    rst_n = 1'b1;
    note("reset");
    run(240);
    note("one minute");

    // 23:59 rolls over to 00:00.
    set_time_to(23, 59);
    run(240);
    note("midnight");

    // Minute edit wraps without hour carry; held inc_hr counts once.
    set_time_to(10, 59);
    set_time = 1'b1; step();
    pulse_min();
    inc_hr = 1'b1; run(20); inc_hr = 1'b0; step();
    set_time = 1'b0; step();
    note("set 11:00");

    // Alarm editing while time runs.
    set_alarm = 1'b1; step();
    for (int i = 0; i < 7; i++) pulse_hr();
    for (int i = 0; i < 30; i++) pulse_min();
    set_alarm = 1'b0; step();
    note("alarm 07:30");

    // Buzz by timeout, by stop, by disarming.
    alarm_en = 1'b1;
    set_time_to(7, 29);
    run(260);
    note("buzz timeout");
    set_time_to(7, 29);
    run(245);
    stop = 1'b1; step(); stop = 1'b0; run(10);
    note("buzz stop");
    set_time_to(7, 29);
    run(245);
    alarm_en = 1'b0; step(); alarm_en = 1'b1; run(5);
    note("buzz disarm");

    // Editing time onto the alarm must stay silent; reset kills buzz.
    set_alarm_to(8, 0);
    set_time_to(7, 59);
    set_time = 1'b1; step();
    pulse_min();
    set_time = 1'b0; run(20);
    note("edit onto alarm");
    set_time_to(7, 59);
    run(245);
    note("buzz before reset");
    rst_n = 1'b0; step(); rst_n = 1'b1; run(8);
    note("reset while buzzing");

    // Randomized levels and button presses.
    alarm_en = 1'b1;
    set_alarm_to(0, 2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 2) set_time = ~set_time;
      if ($urandom_range(99, 0) < 3) set_alarm = ~set_alarm;
      if ($urandom_range(199, 0) < 1) alarm_en = ~alarm_en;
      inc_min = ($urandom_range(99, 0) < 30);
      inc_hr  = ($urandom_range(99, 0) < 20);
      stop    = ($urandom_range(99, 0) < 2);
      rst_n   = ($urandom_range(999, 0) != 0);
      step();
    end
    rst_n = 1'b1; set_time = 1'b0; set_alarm = 1'b0;
    inc_min = 1'b0; inc_hr = 1'b0; stop = 1'b0;
    run(4);
    note("random");

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
